alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that time-shares the 32-bit ALU datapath (AND/OR/ADD with b-invert and carry-in) to run MIPS-style MULTU and DIVU.
- Drives the ALU operand and control inputs every cycle. Consumes the ALU result and carry-out. Returns a 64-bit result as HI/LO.
- Sits beside the ALU in the EX stage. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, data and ALU width; only 32 is supported.
- CNT_W, 5, iteration counter width; WIDTH = 2**CNT_W.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when busy=0
- is_div  input  1  0 = MULTU, 1 = DIVU; sampled with start
- op_a  input  32  multiplicand / dividend
- op_b  input  32  multiplier / divisor
- busy  output  1  high from the cycle after accepted start until the last iteration completes
- done  output  1  one-cycle pulse; hi/lo valid
- hi  output  32  product[63:32] / remainder
- lo  output  32  product[31:0] / quotient
- dz  output  1  divide-by-zero flag (see Optional Feature)
- alu_a  output  32  to ALU inp1
- alu_b  output  32  to ALU inp2
- alu_cin  output  1  to ALU cin
- alu_binv  output  1  to ALU binv
- alu_op  output  2  to ALU op (00 AND, 01 OR, 10 ADD)
- alu_res  input  32  from ALU res
- alu_cout  input  1  from ALU cout

Behaviour:
- Reset values:
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0, dz=0.
  - alu_a=0, alu_b=0, alu_cin=0, alu_binv=0, alu_op=00.
- States: IDLE, MUL, DIV, DONE. busy=1 only in MUL/DIV. done=1 only in DONE.
- IDLE/DONE with start=1:
  - Latch op_b into an internal operand register (opnd).
  - MUL: hi<=0, lo<=op_a. DIV: hi<=0, lo<=op_a.
  - counter<=0, dz<=0.
  - Next state MUL or DIV per is_div.
- start while busy=1 is ignored; no queuing.
- Without start, DONE goes to IDLE after one cycle. hi/lo/dz hold until the next accepted start.
- MUL iteration (one per cycle, 32 cycles):
  - alu_a=hi, alu_b=opnd, alu_op=10, alu_binv=0, alu_cin=0.
  - If lo[0]=1: {hi,lo} <= {alu_cout, alu_res, lo[31:1]}.
  - Else: {hi,lo} <= {1'b0, hi, lo[31:1]}.
- DIV iteration (restoring, 32 cycles):
  - t=hi[31]; alu_a={hi[30:0], lo[31]}, alu_b=opnd, alu_binv=1, alu_cin=1, alu_op=10.
  - q = alu_cout | t.
  - hi <= q ? alu_res : alu_a.
  - lo <= {lo[30:0], q}.
- After the iteration with counter==31, next state is DONE.
- Latency: start accepted at edge N. Iterations run on edges N+1..N+32. done is high during the cycle after edge N+32, i.e. 33 cycles after start.
- ALU control outputs are combinational from state and registers. In IDLE/DONE they are all zero.
- rst_n low at any time, including mid-operation, aborts immediately to the reset values. No done is issued for the aborted operation.
- All arithmetic is unsigned, modulo 2^32 per register. No overflow flag.

Optional Feature:
- Macro: MULDIV_DIVZERO_EN.
- Defined:
  - DIVU with op_b==0 at accept skips iteration and goes straight to DONE.
  - hi=op_a, lo=32'hFFFFFFFF, dz=1.
  - done rises 1 cycle after start.
- Undefined:
  - Divide-by-zero runs the full 32 iterations. The natural result is identical: hi=op_a, lo=32'hFFFFFFFF.
  - dz is tied to 0.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
- MULTU 0x00012345 x 0x00000000 -> hi=0, lo=0. Then MULTU 0x80000000 x 2 -> hi=1, lo=0.
- DIVU 100 / 7 -> lo=14, hi=2. DIVU 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0. DIVU 5 / 9 -> lo=0, hi=5.
- DIVU 0x1234 / 0:
  - with MULDIV_DIVZERO_EN -> done after 1 cycle, dz=1, hi=0x1234, lo=0xFFFFFFFF.
  - without -> done after 33 cycles, dz=0, same hi/lo.
- Second start asserted 10 cycles into a busy MULTU -> ignored; result and done timing are unchanged. A start in the DONE cycle is accepted back-to-back.
- rst_n pulsed low 15 cycles into DIVU -> hi/lo/busy/done/alu_* all 0 asynchronously; no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the EX stage and the MULTU/DIVU sequencer.
// The EX stage is the master; the sequencer is the slave.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_div, op_a, op_b,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, is_div, op_a, op_b,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the EX-stage 32-bit ALU (shift-add / restoring divide).
// Define MULDIV_DIVZERO_EN to short-circuit DIVU by zero to a one-cycle result with the dz flag set.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_muldiv_seq_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_binv,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b10;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] rem_shift;
  logic             quo_bit;

  // Partial remainder shifted left by one; the bit falling out of hi is kept in quo_bit
  // because a set bit there means the shifted remainder already exceeds any 32-bit divisor.
  assign rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign quo_bit   = alu_cout | hi_q[WIDTH-1];

  assign bus.busy = (state == S_MUL) || (state == S_DIV);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

`ifdef MULDIV_DIVZERO_EN
  logic dz_q;
  assign bus.dz = dz_q;
`else
  assign bus.dz = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_binv = 1'b0;
    alu_op   = 2'b00;
    unique case (state)
      S_MUL: begin
        alu_a  = hi_q;
        alu_b  = opnd;
        alu_op = OP_ADD;
      end
      S_DIV: begin
        // a + ~b + 1 = a - b; carry-out set means no borrow
        alu_a    = rem_shift;
        alu_b    = opnd;
        alu_binv = 1'b1;
        alu_cin  = 1'b1;
        alu_op   = OP_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opnd  <= '0;
`ifdef MULDIV_DIVZERO_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            opnd  <= bus.op_b;
            hi_q  <= '0;
            lo_q  <= bus.op_a;
            cnt   <= '0;
            state <= bus.is_div ? S_DIV : S_MUL;
`ifdef MULDIV_DIVZERO_EN
            dz_q  <= 1'b0;
            if (bus.is_div && (bus.op_b == '0)) begin
              hi_q  <= bus.op_a;
              lo_q  <= '1;
              dz_q  <= 1'b1;
              state <= S_DONE;
            end
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (lo_q[0]) begin
            {hi_q, lo_q} <= {alu_cout, alu_res, lo_q[WIDTH-1:1]};
          end else begin
            {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= S_DONE;
        end
        S_DIV: begin
          hi_q <= quo_bit ? alu_res : rem_shift;
          lo_q <= {lo_q[WIDTH-2:0], quo_bit};
          cnt  <= cnt + 1'b1;
          if (cnt == '1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: a behavioural ALU closes the loop, and results and timing
// are compared against plain 64-bit multiply / divide arithmetic.
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(32)) bus ();

  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_binv, alu_cout;
  logic [1:0]  alu_op;

  alu_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_binv (alu_binv),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_cout (alu_cout)
  );

  // Behavioural ALU: 00 AND, 01 OR, 10 ADD, with optional b-invert and carry-in
  logic [31:0] alu_bx;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bx   = alu_binv ? ~alu_b : alu_b;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_bx} + {32'd0, alu_cin};
    alu_res  = '0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00:   alu_res = alu_a & alu_bx;
      2'b01:   alu_res = alu_a | alu_bx;
      2'b10:   {alu_cout, alu_res} = alu_sum;
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: MULTU = full 64-bit product; DIVU = quotient/remainder, with the
  // divide-by-zero convention remainder = dividend, quotient = all ones.
  function automatic exp_t model(bit d, logic [31:0] a, logic [31:0] b, int issue_cyc);
    exp_t        e;
    logic [63:0] p;
    e.dz       = 1'b0;
    e.done_cyc = issue_cyc + 33;
    e.busy_len = 32;
    if (!d) begin
      p    = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
`ifdef MULDIV_DIVZERO_EN
      e.dz       = 1'b1;
      e.done_cyc = issue_cyc + 1;
      e.busy_len = 0;
`endif
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: samples on the falling edge, pops one expectation per done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.busy) busy_run++;
        if (bus.done) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got done=1 expected done=0 (t=%0t)", $time);
          end else begin
            mon_e = sbq.pop_front();
            check("hi", {32'd0, bus.hi}, {32'd0, mon_e.hi});
            check("lo", {32'd0, bus.lo}, {32'd0, mon_e.lo});
            check("dz", {63'd0, bus.dz}, {63'd0, mon_e.dz});
            check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            check("busy_cycles", 64'(busy_run), 64'(mon_e.busy_len));
          end
          busy_run = 0;
        end
      end
    end
  end

  // Caller is at a falling edge; waits for the sequencer to accept, then pushes the expectation.
  task automatic issue(bit d, logic [31:0] a, logic [31:0] b);
    int waited = 0;
    while (bus.busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got busy=1 expected busy=0 within 100 cycles");
    end
    bus.start  = 1'b1;
    bus.is_div = d;
    bus.op_a   = a;
    bus.op_b   = b;
    sbq.push_back(model(d, a, b, cyc));
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_done"}, {63'd0, bus.done}, 64'd0);
    check({tag, "_dz"}, {63'd0, bus.dz}, 64'd0);
    check({tag, "_hi"}, {32'd0, bus.hi}, 64'd0);
    check({tag, "_lo"}, {32'd0, bus.lo}, 64'd0);
    check({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
    check({tag, "_alu_ctl"}, {60'd0, alu_cin, alu_binv, alu_op}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bit          rd;
    int          waited;

    bus.start  = 1'b0;
    bus.is_div = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    rst_n      = 1'b0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases; consecutive issues land in the DONE cycle (back-to-back)
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b0, 32'h0001_2345, 32'h0000_0000);
    issue(1'b0, 32'h8000_0000, 32'h0000_0002);
    issue(1'b1, 32'd100, 32'd7);
    issue(1'b1, 32'hFFFF_FFFF, 32'd1);
    issue(1'b1, 32'd5, 32'd9);
    issue(1'b1, 32'h0000_1234, 32'd0);

    // A start ten cycles into a busy MULTU must be ignored
    issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = 1'b1;
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    @(negedge clk);
    bus.start = 1'b0;

    // Asynchronous abort 15 cycles into a DIVU; no done may follow
    issue(1'b1, $urandom, $urandom | 32'd1);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    sbq.delete();
    busy_run = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue(rd, ra, rb);
    end

    waited = 0;
    while (sbq.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
